// File: rtl/pong_pkg.sv
// Shared Pong constants: screen geometry, ball centre position and the
// ball state encoding used by the ball and paddle blocks.
package pong_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Top-left corner that centres the default 8-pixel ball on the screen.
   localparam int CENTRE_X = 316;
   localparam int CENTRE_Y = 236;

   typedef enum logic [1:0] {
      SERVE = 2'd0,
      PLAY  = 2'd1,
      MISS  = 2'd2
   } ball_state_t;

endpackage

// File: rtl/ball_controller_if.sv
// Video-side bus of the ball controller: raster position, frame update
// strobe and paddle position in; ball pixel and event pulses out.
interface ball_controller_if;

   logic [9:0] x;
   logic [8:0] y;
   logic       update;
   logic [9:0] paddle_x;
   logic       ball_pixel;
   logic       hit;
   logic       missed;

   modport master (
      output x, y, update, paddle_x,
      input  ball_pixel, hit, missed
   );

   modport slave (
      input  x, y, update, paddle_x,
      output ball_pixel, hit, missed
   );

endinterface

// File: rtl/ball_pixel_gen.sv
// Registered rectangle compare: flags the raster pixel one cycle after it
// falls inside the BALL_SIZE x BALL_SIZE square at (bx, by).
module ball_pixel_gen #(
   parameter int BALL_SIZE = 8
) (
   input  logic       clck,
   input  logic       reset_n,
   input  logic       en,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [9:0] bx,
   input  logic [8:0] by,
   output logic       ball_pixel
);

   logic        pix_q, pix_d;
   logic [10:0] x_end;
   logic [9:0]  y_end;

   // Half-open rectangle test, widened by one bit so the right/bottom edge never wraps.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      pix_d = 1'b0;
      x_end = {1'b0, bx} + 11'(BALL_SIZE);
      y_end = {1'b0, by} + 10'(BALL_SIZE);
      if (en && ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} < x_end) &&
          ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} < y_end)) begin
         pix_d = 1'b1;
      end
   end

   // Output register gives the one-cycle pixel latency.
   always_ff @(posedge clck or negedge reset_n) begin
      if (!reset_n) pix_q <= 1'b0;
      else          pix_q <= pix_d;
   end

   assign ball_pixel = pix_q;

endmodule

// File: rtl/ball_controller.sv
// Pong ball motion FSM (SERVE -> PLAY -> MISS) with wall and paddle bounces.
// Optional build macro BALL_SPEEDUP_EN: every 4th paddle hit raises the
// speed by one pixel per update, saturating at 4.
module ball_controller
   import pong_pkg::*;
#(
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_Y     = 464,
   parameter int PADDLE_W     = 64,
   parameter int BASE_SPEED   = 2,
   parameter int SERVE_FRAMES = 60
) (
   input logic              clck,
   input logic              reset_n,
   ball_controller_if.slave bus
);

   localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

   localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
   localparam logic signed [10:0] Y_LIM  = 11'(SCREEN_H);
   localparam logic signed [10:0] BS_S   = 11'(BALL_SIZE);
   localparam logic signed [10:0] PAD_YS = 11'(PADDLE_Y);

   ball_state_t       state_q, state_d;
   logic [9:0]        bx_q, bx_d;
   logic [8:0]        by_q, by_d;
   logic              dirx_q, dirx_d;   // 1: moving right
   logic              diry_q, diry_d;   // 1: moving down
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hit_q, hit_d;
   logic              missed_q, missed_d;
   logic [2:0]        speed;

`ifdef BALL_SPEEDUP_EN
   logic [2:0]        speed_q, speed_d;
   logic [1:0]        hcnt_q, hcnt_d;
   assign speed = speed_q;
`else
   assign speed = 3'(BASE_SPEED);
`endif

   logic signed [10:0] spd_s, nx, ny, ny_bot;
   logic signed [11:0] nx_w, nx_r, pad_l, pad_r;
   logic [9:0]         by_bot;
   logic               overlap, paddle_bounce;

   // Candidate next position (signed, so a step past 0 reads negative) and paddle test.
   always_comb begin
      spd_s  = signed'({8'd0, speed});
      nx     = dirx_q ? (signed'({1'b0, bx_q}) + spd_s) : (signed'({1'b0, bx_q}) - spd_s);
      ny     = diry_q ? (signed'({2'b0, by_q}) + spd_s) : (signed'({2'b0, by_q}) - spd_s);
      ny_bot = ny + BS_S;
      by_bot = {1'b0, by_q} + 10'(BALL_SIZE);
      nx_w   = {nx[10], nx};
      nx_r   = nx_w + signed'(12'(BALL_SIZE));
      pad_l  = signed'({2'b00, bus.paddle_x});
      pad_r  = pad_l + signed'(12'(PADDLE_W));
      overlap       = (nx_w < pad_r) && (nx_r > pad_l);
      paddle_bounce = diry_q && (by_bot <= 10'(PADDLE_Y)) && (ny_bot > PAD_YS) && overlap;
   end

   // Next-state logic: everything holds unless this is an update cycle.
   always_comb begin
      state_d  = state_q;
      bx_d     = bx_q;
      by_d     = by_q;
      dirx_d   = dirx_q;
      diry_d   = diry_q;
      cnt_d    = cnt_q;
      hit_d    = 1'b0;
      missed_d = 1'b0;
`ifdef BALL_SPEEDUP_EN
      speed_d  = speed_q;
      hcnt_d   = hcnt_q;
`endif
      if (bus.update) begin
         case (state_q)
            SERVE: begin
               if (cnt_q == '0) state_d = PLAY;
               else             cnt_d   = cnt_q - 1'b1;
            end
            PLAY: begin
               // Horizontal axis reflects independently of the vertical one.
               if (nx <= 11'sd0) begin
                  bx_d   = '0;
                  dirx_d = 1'b1;
               end else if (nx >= X_MAX) begin
                  bx_d   = 10'(X_MAX);
                  dirx_d = 1'b0;
               end else begin
                  bx_d = nx[9:0];
               end
               if (ny <= 11'sd0) begin
                  by_d   = '0;
                  diry_d = 1'b1;
               end else if (paddle_bounce) begin
                  by_d   = 9'(PADDLE_Y - BALL_SIZE);
                  diry_d = 1'b0;
                  hit_d  = 1'b1;
`ifdef BALL_SPEEDUP_EN
                  hcnt_d = hcnt_q + 1'b1;
                  if ((hcnt_q == 2'd3) && (speed_q < 3'd4)) speed_d = speed_q + 1'b1;
`endif
               end else if (ny >= Y_LIM) begin
                  by_d     = ny[8:0];
                  state_d  = MISS;
                  missed_d = 1'b1;
               end else begin
                  by_d = ny[8:0];
               end
            end
            MISS: begin
               state_d = SERVE;
               bx_d    = 10'(CENTRE_X);
               by_d    = 9'(CENTRE_Y);
               dirx_d  = 1'b1;
               diry_d  = 1'b1;
               cnt_d   = CNT_W'(SERVE_FRAMES);
`ifdef BALL_SPEEDUP_EN
               speed_d = 3'(BASE_SPEED);
               hcnt_d  = '0;
`endif
            end
            default: state_d = SERVE;
         endcase
      end
   end

   // State, position and pulse registers.
   always_ff @(posedge clck or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= SERVE;
         bx_q     <= 10'(CENTRE_X);
         by_q     <= 9'(CENTRE_Y);
         dirx_q   <= 1'b1;
         diry_q   <= 1'b1;
         cnt_q    <= CNT_W'(SERVE_FRAMES);
         hit_q    <= 1'b0;
         missed_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         speed_q  <= 3'(BASE_SPEED);
         hcnt_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
         state_q  <= state_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         dirx_q   <= dirx_d;
         diry_q   <= diry_d;
         cnt_q    <= cnt_d;
         hit_q    <= hit_d;
         missed_q <= missed_d;
`ifdef BALL_SPEEDUP_EN
         speed_q  <= speed_d;
         hcnt_q   <= hcnt_d;
`endif
      end
   end

   assign bus.hit    = hit_q;
   assign bus.missed = missed_q;

   ball_pixel_gen #(
      .BALL_SIZE (BALL_SIZE)
   ) u_pixel (
      .clck       (clck),
      .reset_n    (reset_n),
      .en         (state_q != MISS),
      .x          (bus.x),
      .y          (bus.y),
      .bx         (bx_q),
      .by         (by_q),
      .ball_pixel (bus.ball_pixel)
   );

endmodule

// File: doc/ball_controller.md
BALL_CONTROLLER -- requirements
Module: ball_controller

Interface
REQ-001 Parameter BALL_SIZE, default 8, meaning ball edge length in pixels.
REQ-002 Parameter PADDLE_Y, default 464, meaning top row of paddle.
REQ-003 Parameter PADDLE_W, default 64, meaning paddle width in pixels.
REQ-004 Parameter BASE_SPEED, default 2, meaning pixels moved per axis per update.
REQ-005 Parameter SERVE_FRAMES, default 60, meaning updates spent parked before play.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 Port clck, input, 1, meaning pixel clock; all flops on posedge.
REQ-008 Port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-009 Port x, input, 10, meaning current pixel column from the hsync controller.
REQ-010 Port y, input, 9, meaning current pixel row from the vsync controller.
REQ-011 Port update, input, 1, meaning one-cycle pulse, once per frame during blanking.
REQ-012 Port paddle_x, input, 10, meaning paddle left column, sampled only on update.
REQ-013 Port ball_pixel, output, 1, meaning current pixel lies inside the ball.
REQ-014 Port hit, output, 1, meaning one-cycle pulse on paddle bounce.
REQ-015 Port missed, output, 1, meaning one-cycle pulse when the ball leaves the bottom edge.

Function
REQ-016 States SERVE, PLAY, MISS; the position registers bx (10 bit) and by (9 bit) hold the ball's top-left corner.
REQ-017 State, position, direction, speed and serve counter change only in a cycle where update=1; all other cycles hold them.
REQ-018 SERVE: each update decrements the serve counter; on the update where the counter is 0, the state becomes PLAY and the ball makes no move on that update.
REQ-019 PLAY: next position = position +/- speed per axis, computed 11-bit signed to avoid wrap.
REQ-020 Left/right wall: next x <= 0 -> bx=0, dirx=+; next x >= 640-BALL_SIZE -> bx=640-BALL_SIZE, dirx=-.
REQ-021 Top wall: next y <= 0 -> by=0, diry=+.
REQ-022 Paddle: diry=+, by+BALL_SIZE <= PADDLE_Y, next by+BALL_SIZE > PADDLE_Y, and horizontal overlap of [next x, next x+BALL_SIZE) with [paddle_x, paddle_x+PADDLE_W) -> by=PADDLE_Y-BALL_SIZE, diry=-, hit=1 for one cycle.
REQ-023 Without a paddle bounce, next y >= 480 -> state MISS, missed=1 for one cycle.
REQ-024 When corner conditions occur, each axis reflects independently in the same update.
REQ-025 MISS: the next update sets bx=316, by=236, dirx=+, diry=+, speed=BASE_SPEED, counter=SERVE_FRAMES, and the state becomes SERVE.
REQ-026 ball_pixel is registered: it is 1 one cycle after x in [bx,bx+BALL_SIZE) and y in [by,by+BALL_SIZE), and is forced 0 in MISS.

Reset
REQ-027 reset_n=0 asynchronously forces SERVE, bx=316, by=236, dirx=+, diry=+, speed=BASE_SPEED, counter=SERVE_FRAMES, ball_pixel=0, hit=0, missed=0.
REQ-028 Reset asserted mid-frame or mid-pulse clears hit/missed immediately; no pulse is emitted on reset release.

Configuration
REQ-029 With BALL_SPEEDUP_EN defined, every 4th hit increments speed, saturating at 4 with a 2-bit hit counter cleared on serve; without it, speed stays BASE_SPEED and no hit counter exists.

Structure
REQ-030 Package pong_pkg shall hold the screen constants (640, 480), the centre coordinates, and the ball_state_t enum shared with the paddle block.
REQ-031 Sub-module ball_pixel_gen shall hold the registered rectangle compare of REQ-026; the motion FSM stays in ball_controller.

Verification
REQ-032 Reset, then 60 updates -> the ball is stationary at (316,236); on the 61st update it enters PLAY, and the 62nd update moves it to (318,238).
REQ-033 bx=630, dirx=+ on update -> bx=632, dirx=-; the next update gives bx=630.
REQ-034 by=455, diry=+, paddle_x=300, bx=310 on update -> by=456, diry=-, hit pulse of exactly 1 cycle.
REQ-035 Same as REQ-034 with paddle_x=400 -> no hit; subsequent updates reach y>=480, then missed pulses once, then SERVE at (316,236).
REQ-036 Scan with ball at (100,50) -> ball_pixel high for x 100..107 on rows 50..57, one cycle after the matching x; it is 0 elsewhere.
REQ-037 With BALL_SPEEDUP_EN, 4 consecutive hits -> speed 3; 8 more hits -> speed saturates at 4; reset_n pulse mid-line -> all outputs 0 asynchronously.
